// File: rtl/operand_bypass_stage_pkg.sv
// Shared opcode/funct definitions and operand-select decode for the
// operand bypass stage. Includes the ANDI/ORI/XORI codes.
package operand_bypass_stage_pkg;

    // Register index width (32 architectural registers)
    localparam int REG_W = 5;

    // Primary opcodes
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_XORI    = 6'h0E;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LB      = 6'h20;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_LBU     = 6'h24;
    localparam logic [5:0] OPC_SB      = 6'h28;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    // SPECIAL function codes
    localparam logic [5:0] FUNCT_JALR  = 6'h09;

    // Source selection for operand_1
    typedef enum logic [1:0] {
        OP1_ZERO = 2'd0,
        OP1_LINK = 2'd1,   // return address addr+8
        OP1_RS   = 2'd2
    } op1_sel_e;

    // Source selection for operand_2
    typedef enum logic [2:0] {
        OP2_ZERO  = 3'd0,
        OP2_UPPER = 3'd1,  // {imm,16'b0}
        OP2_SEXT  = 3'd2,
        OP2_ZEXT  = 3'd3,
        OP2_RT    = 3'd4
    } op2_sel_e;

    typedef struct packed {
        op1_sel_e op1;
        op2_sel_e op2;
    } opsel_t;

    // Map opcode/funct to operand sources. Anything not listed yields zeros.
    function automatic opsel_t decode_opsel(input logic [5:0] op,
                                            input logic [5:0] funct);
        opsel_t s;
        s.op1 = OP1_ZERO;
        s.op2 = OP2_ZERO;
        case (op)
            OPC_JAL: begin
                s.op1 = OP1_LINK;
            end
            OPC_SPECIAL: begin
                s.op1 = (funct == FUNCT_JALR) ? OP1_LINK : OP1_RS;
                s.op2 = OP2_RT;
            end
            OPC_ADDI, OPC_ADDIU,
            OPC_LB, OPC_LBU, OPC_LW, OPC_SB, OPC_SW: begin
                s.op1 = OP1_RS;
                s.op2 = OP2_SEXT;
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                s.op1 = OP1_RS;
                s.op2 = OP2_ZEXT;
            end
            OPC_LUI: begin
                s.op1 = OP1_RS;
                s.op2 = OP2_UPPER;
            end
            default: begin
                s.op1 = OP1_ZERO;
                s.op2 = OP2_ZERO;
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/operand_bypass_stage_fwd_mux.sv
// fwd_mux: priority forward selection for one source register.
// The lowest-index valid source whose destination matches wins; register 0
// is hardwired to zero and never reports a pending forward.
module fwd_mux
    import operand_bypass_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int FWD_N  = 2
) (
    input  logic [REG_W-1:0]        i_reg_addr,
    input  logic [DATA_W-1:0]       i_rf_data,
    input  logic [FWD_N-1:0]        i_fwd_valid,
    input  logic [FWD_N-1:0]        i_fwd_pending,
    input  logic [FWD_N*REG_W-1:0]  i_fwd_waddr,
    input  logic [FWD_N*DATA_W-1:0] i_fwd_wdata,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_pending
);

    logic [DATA_W-1:0] w_data;
    logic              w_pending;

    // Scan oldest to youngest so the youngest (lowest index) match overwrites
    always_comb begin
        w_data    = i_rf_data;
        w_pending = 1'b0;
        for (int k = FWD_N - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && (i_fwd_waddr[k*REG_W +: REG_W] == i_reg_addr)) begin
                w_data    = i_fwd_wdata[k*DATA_W +: DATA_W];
                w_pending = i_fwd_pending[k];
            end
        end
        if (i_reg_addr == '0) begin
            w_data    = '0;
            w_pending = 1'b0;
        end
    end

    assign o_data    = w_data;
    assign o_pending = w_pending;

endmodule

// File: rtl/operand_bypass_stage.sv
// operand_bypass_stage: resolves rs/rt through the forwarding network,
// builds execute operands from the decoded instruction and registers them
// behind a single valid/ready output slot. Load-use hazards (winning forward
// still pending) stall the input and insert a bubble.
// Optional: define OPERAND_STALL_CNT_EN to add the 32-bit stall_cnt output.
module operand_bypass_stage
    import operand_bypass_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int FWD_N  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    output logic                    id_ready,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [5:0]              op,
    input  logic [5:0]              funct,
    input  logic [15:0]             imm,
    input  logic [4:0]              rs_addr,
    input  logic [4:0]              rt_addr,
    input  logic [DATA_W-1:0]       reg_data_1,
    input  logic [DATA_W-1:0]       reg_data_2,
    input  logic [FWD_N-1:0]        fwd_valid,
    input  logic [FWD_N-1:0]        fwd_pending,
    input  logic [FWD_N*5-1:0]      fwd_waddr,
    input  logic [FWD_N*DATA_W-1:0] fwd_wdata,
    input  logic                    flush,
    output logic                    ex_valid,
    input  logic                    ex_ready,
    output logic [DATA_W-1:0]       operand_1,
    output logic [DATA_W-1:0]       operand_2
`ifdef OPERAND_STALL_CNT_EN
   ,output logic [31:0]             stall_cnt
`endif
);

    logic [DATA_W-1:0] w_rs_val;
    logic [DATA_W-1:0] w_rt_val;
    logic              w_rs_pend;
    logic              w_rt_pend;
    opsel_t            w_opsel;
    logic [ADDR_W-1:0] w_link;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;
    logic              w_hazard;
    logic              w_free;
    logic              w_accept;

    logic              r_ex_valid;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;

    // Forward resolution for rs
    fwd_mux #(
        .DATA_W (DATA_W),
        .FWD_N  (FWD_N)
    ) u_fwd_rs (
        .i_reg_addr    (rs_addr),
        .i_rf_data     (reg_data_1),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_pending (fwd_pending),
        .i_fwd_waddr   (fwd_waddr),
        .i_fwd_wdata   (fwd_wdata),
        .o_data        (w_rs_val),
        .o_pending     (w_rs_pend)
    );

    // Forward resolution for rt
    fwd_mux #(
        .DATA_W (DATA_W),
        .FWD_N  (FWD_N)
    ) u_fwd_rt (
        .i_reg_addr    (rt_addr),
        .i_rf_data     (reg_data_2),
        .i_fwd_valid   (fwd_valid),
        .i_fwd_pending (fwd_pending),
        .i_fwd_waddr   (fwd_waddr),
        .i_fwd_wdata   (fwd_wdata),
        .o_data        (w_rt_val),
        .o_pending     (w_rt_pend)
    );

    assign w_opsel = decode_opsel(op, funct);
    assign w_link  = addr + ADDR_W'(8);

    // Operand construction from the selected sources
    always_comb begin
        w_op1 = '0;
        case (w_opsel.op1)
            OP1_LINK: w_op1 = DATA_W'(w_link);
            OP1_RS:   w_op1 = w_rs_val;
            default:  w_op1 = '0;
        endcase

        w_op2 = '0;
        case (w_opsel.op2)
            OP2_UPPER: w_op2 = DATA_W'({imm, 16'b0});
            OP2_SEXT:  w_op2 = {{(DATA_W-16){imm[15]}}, imm};
            OP2_ZEXT:  w_op2 = {{(DATA_W-16){1'b0}}, imm};
            OP2_RT:    w_op2 = w_rt_val;
            default:   w_op2 = '0;
        endcase
    end

    // A pending forward only matters if the instruction actually reads it
    assign w_hazard = ((w_opsel.op1 == OP1_RS) && w_rs_pend) ||
                      ((w_opsel.op2 == OP2_RT) && w_rt_pend);

    assign w_free   = !r_ex_valid || ex_ready;
    assign w_accept = id_valid && w_free && !w_hazard && !flush;
    assign id_ready = w_accept && !rst;

    // Output slot: reset > flush > load; holds while execute backpressures
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex_valid <= 1'b0;
            r_op1      <= '0;
            r_op2      <= '0;
        end else if (flush) begin
            r_ex_valid <= 1'b0;
        end else if (w_free) begin
            r_ex_valid <= w_accept;
            if (w_accept) begin
                r_op1 <= w_op1;
                r_op2 <= w_op2;
            end
        end
    end

    assign ex_valid  = r_ex_valid;
    assign operand_1 = r_op1;
    assign operand_2 = r_op2;

`ifdef OPERAND_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    // Saturating count of cycles an instruction waits on a pending forward
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (id_valid && w_hazard && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_operand_bypass_stage.sv
// Scoreboard bench for operand_bypass_stage: directed vectors push expected
// operands on acceptance; a negedge monitor pops and compares on each
// ex_valid & ex_ready handshake.
module tb_operand_bypass_stage;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int FWD_N  = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    id_valid;
    logic                    id_ready;
    logic [ADDR_W-1:0]       addr;
    logic [5:0]              op;
    logic [5:0]              funct;
    logic [15:0]             imm;
    logic [4:0]              rs_addr;
    logic [4:0]              rt_addr;
    logic [DATA_W-1:0]       reg_data_1;
    logic [DATA_W-1:0]       reg_data_2;
    logic [FWD_N-1:0]        fwd_valid;
    logic [FWD_N-1:0]        fwd_pending;
    logic [FWD_N*5-1:0]      fwd_waddr;
    logic [FWD_N*DATA_W-1:0] fwd_wdata;
    logic                    flush;
    logic                    ex_valid;
    logic                    ex_ready;
    logic [DATA_W-1:0]       operand_1;
    logic [DATA_W-1:0]       operand_2;
`ifdef OPERAND_STALL_CNT_EN
    logic [31:0]             stall_cnt;
`endif

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    operand_bypass_stage #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FWD_N  (FWD_N)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .addr        (addr),
        .op          (op),
        .funct       (funct),
        .imm         (imm),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .reg_data_1  (reg_data_1),
        .reg_data_2  (reg_data_2),
        .fwd_valid   (fwd_valid),
        .fwd_pending (fwd_pending),
        .fwd_waddr   (fwd_waddr),
        .fwd_wdata   (fwd_wdata),
        .flush       (flush),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .operand_1   (operand_1),
        .operand_2   (operand_2)
`ifdef OPERAND_STALL_CNT_EN
       ,.stall_cnt   (stall_cnt)
`endif
    );

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: every output handshake must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %0h/%0h expected none",
                         operand_1, operand_2);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ex_operand_1", operand_1, e.op1);
                chk("ex_operand_2", operand_2, e.op2);
            end
        end
    end

    task automatic clear_fwd();
        fwd_valid   = '0;
        fwd_pending = '0;
        fwd_waddr   = '0;
        fwd_wdata   = '0;
    endtask

    task automatic set_fwd(input int i, input logic v, input logic p,
                           input logic [4:0] wa, input logic [31:0] wd);
        fwd_valid[i]            = v;
        fwd_pending[i]          = p;
        fwd_waddr[i*5 +: 5]     = wa;
        fwd_wdata[i*DATA_W +: DATA_W] = wd;
    endtask

    task automatic drive(input logic [5:0] t_op, input logic [5:0] t_funct,
                         input logic [15:0] t_imm, input logic [31:0] t_addr,
                         input logic [4:0] t_rs, input logic [4:0] t_rt,
                         input logic [31:0] t_d1, input logic [31:0] t_d2);
        op = t_op; funct = t_funct; imm = t_imm; addr = t_addr;
        rs_addr = t_rs; rt_addr = t_rt; reg_data_1 = t_d1; reg_data_2 = t_d2;
        id_valid = 1'b1;
    endtask

    // Present an instruction, wait (bounded) for acceptance, queue expectation
    task automatic issue(input logic [5:0] t_op, input logic [5:0] t_funct,
                         input logic [15:0] t_imm, input logic [31:0] t_addr,
                         input logic [4:0] t_rs, input logic [4:0] t_rt,
                         input logic [31:0] t_d1, input logic [31:0] t_d2,
                         input logic [31:0] e1, input logic [31:0] e2);
        bit   ok;
        exp_t e;
        drive(t_op, t_funct, t_imm, t_addr, t_rs, t_rt, t_d1, t_d2);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (id_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got id_ready=0 expected acceptance op=%0h", t_op);
        end else begin
            e.op1 = e1;
            e.op2 = e2;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        id_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        clear_fwd();
        // Valid input during reset must be ignored
        drive(6'h09, 6'h00, 16'h0001, 32'h0, 5'd1, 5'd0, 32'h1, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", ex_valid, 0);
        chk("rst_operand_1", operand_1, 0);
        chk("rst_operand_2", operand_2, 0);
        chk("rst_id_ready", id_ready, 0);
`ifdef OPERAND_STALL_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0; id_valid = 1'b0;

        // Operand construction, no forwarding
        issue(6'h09, 6'h00, 16'hFFFF, 32'h0,   5'd3, 5'd0, 32'h5,    32'h0,  32'h5,     32'hFFFFFFFF); // ADDIU
        issue(6'h0D, 6'h00, 16'h8000, 32'h0,   5'd2, 5'd0, 32'h10,   32'h0,  32'h10,    32'h00008000); // ORI
        issue(6'h03, 6'h00, 16'h0000, 32'h100, 5'd0, 5'd0, 32'h0,    32'h0,  32'h108,   32'h0);        // JAL
        issue(6'h0F, 6'h00, 16'h1234, 32'h0,   5'd0, 5'd0, 32'h99,   32'h0,  32'h0,     32'h12340000); // LUI, rs=0
        issue(6'h0C, 6'h00, 16'h8001, 32'h0,   5'd5, 5'd0, 32'hF0F0, 32'h0,  32'hF0F0,  32'h00008001); // ANDI
        issue(6'h08, 6'h00, 16'h8000, 32'h0,   5'd5, 5'd0, 32'h7,    32'h0,  32'h7,     32'hFFFF8000); // ADDI
        issue(6'h23, 6'h00, 16'hFFFC, 32'h0,   5'd9, 5'd0, 32'h1000, 32'h0,  32'h1000,  32'hFFFFFFFC); // LW
        issue(6'h28, 6'h00, 16'h0004, 32'h0,   5'd9, 5'd0, 32'h1000, 32'h0,  32'h1000,  32'h4);        // SB
        issue(6'h00, 6'h09, 16'h0000, 32'h200, 5'd7, 5'd3, 32'hAA,   32'hBB, 32'h208,   32'hBB);       // JALR
        issue(6'h00, 6'h21, 16'h0000, 32'h0,   5'd7, 5'd3, 32'hAA,   32'hBB, 32'hAA,    32'hBB);       // ADDU
        issue(6'h04, 6'h00, 16'h0010, 32'h0,   5'd1, 5'd2, 32'h1,    32'h2,  32'h0,     32'h0);        // BEQ -> zeros

        // Forwarding priority and register 0
        set_fwd(0, 1'b1, 1'b0, 5'd4, 32'hA);
        set_fwd(1, 1'b1, 1'b0, 5'd4, 32'hB);
        issue(6'h00, 6'h21, 16'h0, 32'h0, 5'd4, 5'd5, 32'h77, 32'h33, 32'hA, 32'h33);
        set_fwd(0, 1'b1, 1'b0, 5'd9, 32'h1);
        issue(6'h09, 6'h00, 16'h0, 32'h0, 5'd4, 5'd0, 32'h77, 32'h0, 32'hB, 32'h0);
        set_fwd(0, 1'b1, 1'b0, 5'd5, 32'hCC);
        issue(6'h00, 6'h21, 16'h0, 32'h0, 5'd9, 5'd5, 32'h77, 32'h33, 32'h77, 32'hCC);
        set_fwd(0, 1'b1, 1'b0, 5'd0, 32'h55);
        set_fwd(1, 1'b1, 1'b0, 5'd0, 32'h55);
        issue(6'h00, 6'h21, 16'h0, 32'h0, 5'd0, 5'd0, 32'h66, 32'h66, 32'h0, 32'h0);
        clear_fwd();

        // Load-use hazard held for four edges
        set_fwd(0, 1'b1, 1'b1, 5'd6, 32'h0);
        drive(6'h09, 6'h00, 16'h0001, 32'h0, 5'd6, 5'd0, 32'h11, 32'h0);
        @(negedge clk);
        chk("hazard_id_ready", id_ready, 0);
        @(negedge clk);
        chk("hazard_bubble", ex_valid, 0);
        chk("hazard_id_ready_hold", id_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        set_fwd(0, 1'b1, 1'b0, 5'd6, 32'h42);
        @(negedge clk);
        chk("hazard_release_id_ready", id_ready, 1);
`ifdef OPERAND_STALL_CNT_EN
        chk("stall_cnt_4", stall_cnt, 4);
`endif
        e.op1 = 32'h42; e.op2 = 32'h1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        id_valid = 1'b0;
        clear_fwd();

        // Only the winning source decides the hazard
        set_fwd(0, 1'b1, 1'b0, 5'd8, 32'hC0);
        set_fwd(1, 1'b1, 1'b1, 5'd8, 32'hD0);
        drive(6'h09, 6'h00, 16'h0002, 32'h0, 5'd8, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("win_not_pending_id_ready", id_ready, 1);
        e.op1 = 32'hC0; e.op2 = 32'h2;
        exp_q.push_back(e);
        @(posedge clk); #1;
        id_valid = 1'b0;
        set_fwd(0, 1'b1, 1'b1, 5'd8, 32'h0);
        set_fwd(1, 1'b1, 1'b0, 5'd8, 32'hD0);
        drive(6'h09, 6'h00, 16'h0003, 32'h0, 5'd8, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("win_pending_id_ready", id_ready, 0);
        @(posedge clk); #1;
        set_fwd(0, 1'b1, 1'b0, 5'd8, 32'hE0);
        issue(6'h09, 6'h00, 16'h0003, 32'h0, 5'd8, 5'd0, 32'h0, 32'h0, 32'hE0, 32'h3);
        clear_fwd();

        // Backpressure: three stalled cycles, operands stable
        issue(6'h00, 6'h21, 16'h0, 32'h0, 5'd1, 5'd2, 32'h111, 32'h222, 32'h111, 32'h222);
        ex_ready = 1'b0;
        drive(6'h09, 6'h00, 16'h0007, 32'h0, 5'd1, 5'd0, 32'h9, 32'h0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_ex_valid", ex_valid, 1);
            chk("stall_operand_1", operand_1, 32'h111);
            chk("stall_operand_2", operand_2, 32'h222);
            chk("stall_id_ready", id_ready, 0);
        end
        @(posedge clk); #1;
        id_valid = 1'b0;
        ex_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;

        // Flush during backpressure
        issue(6'h00, 6'h21, 16'h0, 32'h0, 5'd1, 5'd2, 32'h333, 32'h444, 32'h333, 32'h444);
        ex_ready = 1'b0;
        drive(6'h09, 6'h00, 16'h0007, 32'h0, 5'd1, 5'd0, 32'h9, 32'h0);
        @(negedge clk);
        chk("flush_pre_operand_1", operand_1, 32'h333);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_ex_valid", ex_valid, 1);
        @(posedge clk); #1;
        ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_clears_ex_valid", ex_valid, 0);
        chk("flush_id_ready", id_ready, 0);
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        flush = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);
        chk("flush_no_load", ex_valid, 0);
        @(posedge clk); #1;

        // Reset mid-stream with a held output
        issue(6'h0D, 6'h00, 16'h00FF, 32'h0, 5'd2, 5'd0, 32'h1, 32'h0, 32'h1, 32'hFF);
        ex_ready = 1'b0;
        @(negedge clk);
        chk("pre_rst_ex_valid", ex_valid, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(6'h09, 6'h00, 16'h0005, 32'h0, 5'd1, 5'd0, 32'h9, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ex_valid", ex_valid, 0);
        chk("mid_rst_operand_1", operand_1, 0);
        chk("mid_rst_operand_2", operand_2, 0);
        chk("mid_rst_id_ready", id_ready, 0);
`ifdef OPERAND_STALL_CNT_EN
        chk("mid_rst_stall_cnt", stall_cnt, 0);
`endif
        void'(exp_q.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        id_valid = 1'b0;
        ex_ready = 1'b1;
        issue(6'h0E, 6'h00, 16'hF00F, 32'h0, 5'd3, 5'd0, 32'h1234, 32'h0, 32'h1234, 32'h0000F00F); // XORI

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_bypass_stage.md
OPERAND_BYPASS_STAGE -- requirements
Module: operand_bypass_stage

Interface
REQ-001 Parameter DATA_W, default 32, operand and data width.
REQ-002 Parameter ADDR_W, default 32, instruction address width.
REQ-003 Parameter FWD_N, default 2, number of forwarding sources; index 0 is the youngest stage.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 id_valid  in  1  decoded instruction present.
REQ-007 id_ready  out  1  instruction accepted this cycle.
REQ-008 addr, op, funct, imm  in  ADDR_W/6/6/16  PC, opcode, function code and immediate.
REQ-009 rs_addr, rt_addr  in  5/5  source register indices.
REQ-010 reg_data_1, reg_data_2  in  DATA_W each  register-file read data.
REQ-011 fwd_valid, fwd_pending  in  FWD_N each  forward entry valid; data not yet available (load).
REQ-012 fwd_waddr, fwd_wdata  in  FWD_N*5, FWD_N*DATA_W  destination index and result per source.
REQ-013 flush  in  1  kill the registered instruction and the in-flight input.
REQ-014 ex_valid  out  1  operands valid toward execute.
REQ-015 ex_ready  in  1  execute accepts this cycle.
REQ-016 operand_1, operand_2  out  DATA_W each  registered operands.

Function
REQ-017 rs_val/rt_val: take the lowest-index source with fwd_valid=1 and a matching fwd_waddr; otherwise use the register-file data; index 0 is never forwarded and always reads 0.
REQ-018 operand_1: addr+8 for JAL and for SPECIAL with JALR; rs_val for ADDI, ADDIU, ANDI, ORI, XORI, LUI, LB, LBU, LW, SB, SW and other SPECIAL; 0 otherwise.
REQ-019 operand_2: {imm,16'b0} for LUI; sign-extended imm for ADDI, ADDIU and the loads/stores; zero-extended imm for ANDI, ORI and XORI; rt_val for SPECIAL; 0 otherwise.
REQ-020 Hazard is asserted when an operand actually consumes rs (or rt) and the winning forward match for it has fwd_pending=1.
REQ-021 Output register loads when ex_ready=1 or ex_valid=0 (slot free).
REQ-022 id_ready = id_valid & slot free & !hazard & !flush.
REQ-023 When the slot is free and hazard=1, ex_valid becomes 0 next cycle (bubble) and the input is held.
REQ-024 Latency is one cycle from acceptance to ex_valid.
REQ-025 With ex_valid=1 and ex_ready=0, operands and ex_valid hold stable.
REQ-026 flush=1 clears ex_valid next cycle, overrides any load, and deasserts id_ready.
REQ-027 If several sources match with different pending states, only the winning (lowest-index) source decides the hazard.

Reset
REQ-028 With rst=1 at a clock edge: ex_valid=0, operand_1=0, operand_2=0 and the stall counter is 0; reset wins over flush and load.
REQ-029 id_ready is 0 while rst=1.

Configuration
REQ-030 With OPERAND_STALL_CNT_EN defined: output stall_cnt (32 bits) counts cycles where id_valid=1 and hazard=1, saturates at all-ones, and clears on reset.
REQ-031 Without OPERAND_STALL_CNT_EN: no stall_cnt port and no counter logic.

Structure
REQ-032 Opcode and funct constants come from the shared opcode/funct definitions; the new ANDI/ORI/XORI codes are added there.
REQ-033 The forward-priority match is a sub-module, fwd_mux, instantiated once per source operand.

Verification
REQ-034 ADDIU, rs=3, reg_data_1=5, imm=16'hFFFF, no forwards -> operand_1=5, operand_2=32'hFFFFFFFF one cycle later.
REQ-035 ORI with imm=16'h8000 -> operand_2=32'h00008000; JAL at addr=0x100 -> operand_1=0x108, operand_2=0.
REQ-036 Forward sources 0 and 1 both target reg 4 with data 0xA and 0xB -> rs_val=0xA; fwd_waddr=0 with data 0x55 -> forwarding is ignored and the operand is 0.
REQ-037 Source 0 matches rs with fwd_pending=1 -> id_ready=0 and a one-cycle bubble (ex_valid=0); the instruction is issued on the cycle after pending drops.
REQ-038 ex_ready=0 for 3 cycles with ex_valid=1 -> operands stable; flush in the 2nd cycle -> ex_valid=0 next cycle.
REQ-039 rst asserted mid-stream -> all outputs 0 next edge; with OPERAND_STALL_CNT_EN, 4 hazard cycles -> stall_cnt=4.
